// File: rtl/tmds_encoder.sv
// Three-channel TMDS encoder: RGB888 + sync + DE in, three 10-bit symbols out.
// Ports: clk_pixel, reset_i (sync, active-high), red_i/green_i/blue_i [7:0],
//        hsync_i, vsync_i, vde_i in; tmds_r_o/tmds_g_o/tmds_b_o [9:0] out.
// Pipeline: input register, q_m register, symbol/disparity register.
// Inputs captured at edge k appear on the outputs after edge k+2.
module tmds_encoder (
    input  logic       clk_pixel,
    input  logic       reset_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       vde_i,
    output logic [9:0] tmds_r_o,
    output logic [9:0] tmds_g_o,
    output logic [9:0] tmds_b_o
);

    function automatic logic [3:0] f_pop(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage; q_m[8]=1 marks the XOR variant.
    function automatic logic [8:0] f_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       xn;
        logic [8:0] q;
        n1   = f_pop(d);
        xn   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~xn;
        return q;
    endfunction

    // DC-balancing stage. bal = n1 - n0 of q_m[7:0], range -8..8.
    function automatic void f_enc(
        input  logic [8:0]        qm,
        input  logic              de,
        input  logic [1:0]        c,
        input  logic signed [4:0] cnt,
        output logic [9:0]        sym,
        output logic signed [4:0] cnt_n
    );
        logic signed [4:0] n1;
        logic signed [4:0] n0;
        logic signed [4:0] bal;
        n1  = $signed({1'b0, f_pop(qm[7:0])});
        n0  = 5'sd8 - n1;
        bal = n1 - n0;
        if (!de) begin
            cnt_n = 5'sd0;
            case (c)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
        end else if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
            sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_n = qm[8] ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                     ((cnt < 5'sd0) && (bal < 5'sd0))) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) - bal;
        end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            cnt_n = cnt - (qm[8] ? 5'sd0 : 5'sd2) + bal;
        end
    endfunction

    logic [7:0] w_d [3];
    logic [1:0] w_ctrl [3];
    logic [9:0] r_out [3];

    logic [1:0] r_in_ctrl;
    logic       r_in_de;
    logic [1:0] r_qm_ctrl;
    logic       r_qm_de;

    assign w_d[0] = red_i;
    assign w_d[1] = green_i;
    assign w_d[2] = blue_i;

    // Only blue carries sync; red/green always send the 00 token.
    assign w_ctrl[0] = 2'b00;
    assign w_ctrl[1] = 2'b00;
    assign w_ctrl[2] = r_qm_ctrl;

    always_ff @(posedge clk_pixel) begin
        if (reset_i) begin
            r_in_ctrl <= 2'b00;
            r_in_de   <= 1'b0;
            r_qm_ctrl <= 2'b00;
            r_qm_de   <= 1'b0;
        end else begin
            r_in_ctrl <= {vsync_i, hsync_i};
            r_in_de   <= vde_i;
            r_qm_ctrl <= r_in_ctrl;
            r_qm_de   <= r_in_de;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [7:0]        r_d;
        logic [8:0]        r_qm;
        logic signed [4:0] r_cnt;
        logic [9:0]        w_sym;
        logic signed [4:0] w_cnt;

        always_comb begin
            w_sym = 10'h354;
            w_cnt = 5'sd0;
            f_enc(r_qm, r_qm_de, w_ctrl[ch], r_cnt, w_sym, w_cnt);
        end

        always_ff @(posedge clk_pixel) begin
            if (reset_i) begin
                r_d       <= '0;
                r_qm      <= '0;
                r_cnt     <= 5'sd0;
                r_out[ch] <= 10'h354;
            end else begin
                r_d       <= w_d[ch];
                r_qm      <= f_qm(r_d);
                r_cnt     <= w_cnt;
                r_out[ch] <= w_sym;
            end
        end
    end

    assign tmds_r_o = r_out[0];
    assign tmds_g_o = r_out[1];
    assign tmds_b_o = r_out[2];

endmodule
